// File: rtl/dr_memreq_sched.sv
// dr_memreq_sched: merges demand misses and L2 prefetches onto one memory
// request channel. Demand has priority; a starvation counter forces a
// prefetch grant after PF_STARVE consecutive demand grants. A full prefetch
// queue overwrites its oldest entry instead of back-pressuring.
// Optional macro DR_PF_DEDUP_EN: discard prefetches whose line address is
// already pending in the prefetch queue or the output register.
module dr_memreq_sched #(
  parameter int                   REQ_DEPTH = 8,
  parameter int                   PF_DEPTH  = 8,
  parameter int                   PADDR_W   = 50,
  parameter int                   NID_W     = 5,
  parameter int                   DRID_W    = 6,
  parameter int                   CMD_W     = 3,
  parameter int                   PF_STARVE = 15,
  parameter logic [CMD_W-1:0]     PF_CMD    = 3'd1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               l2todr_req_valid,
  output logic               l2todr_req_retry,
  input  logic [DRID_W-1:0]  l2todr_req_drid,
  input  logic [CMD_W-1:0]   l2todr_req_cmd,
  input  logic [PADDR_W-1:0] l2todr_req_paddr,
  input  logic               l2todr_pfreq_valid,
  output logic               l2todr_pfreq_retry,
  input  logic [NID_W-1:0]   l2todr_pfreq_nid,
  input  logic [PADDR_W-1:0] l2todr_pfreq_paddr,
  output logic               drtomem_req_valid,
  input  logic               drtomem_req_retry,
  output logic [DRID_W-1:0]  drtomem_req_drid,
  output logic [CMD_W-1:0]   drtomem_req_cmd,
  output logic [PADDR_W-1:0] drtomem_req_paddr,
  output logic [NID_W-1:0]   drtomem_req_nid,
  output logic               drtomem_req_pf,
  output logic [15:0]        pf_drop_cnt
);

  localparam int RA_W  = $clog2(REQ_DEPTH);
  localparam int PA_W  = $clog2(PF_DEPTH);
  localparam int ST_W  = $clog2(PF_STARVE + 1);
  localparam int REQ_W = DRID_W + CMD_W + PADDR_W;
  localparam int PF_W  = NID_W + PADDR_W;
  localparam logic [RA_W:0] REQ_FULL = (RA_W + 1)'(REQ_DEPTH);
  localparam logic [PA_W:0] PF_FULL  = (PA_W + 1)'(PF_DEPTH);

  // Queue storage (no reset: contents are qualified by pointers/counts)
  logic [REQ_W-1:0] req_mem [REQ_DEPTH];
  logic [PF_W-1:0]  pf_mem  [PF_DEPTH];

  logic [RA_W-1:0] req_wr_ptr_reg, req_rd_ptr_reg;
  logic [RA_W:0]   req_count_reg;
  logic            req_retry_reg;
  logic [PA_W-1:0] pf_wr_ptr_reg, pf_rd_ptr_reg;
  logic [PA_W:0]   pf_count_reg;
  logic [ST_W-1:0] starve_cnt_reg;
  logic [15:0]     pf_drop_cnt_reg;

  logic               out_valid_reg;
  logic [DRID_W-1:0]  out_drid_reg;
  logic [CMD_W-1:0]   out_cmd_reg;
  logic [PADDR_W-1:0] out_paddr_reg;
  logic [NID_W-1:0]   out_nid_reg;
  logic               out_pf_reg;

  logic req_push, req_pop, req_empty;
  logic pf_push, pf_pop, pf_empty, pf_full, pf_overwrite, pf_drop_evt;
  logic dedup_hit;
  logic load_en, take_d, take_p;
  logic [RA_W:0] req_count_next;

  assign req_empty = (req_count_reg == '0);
  assign pf_empty  = (pf_count_reg == '0);
  assign pf_full   = (pf_count_reg == PF_FULL);

  // Output register refills when empty or when its entry leaves this cycle
  assign load_en = !out_valid_reg || !drtomem_req_retry;
  assign take_d  = !req_empty && (pf_empty || (starve_cnt_reg != ST_W'(PF_STARVE)));
  assign take_p  = !pf_empty && !take_d;
  assign req_pop = load_en && take_d;
  assign pf_pop  = load_en && take_p;

  assign req_push = l2todr_req_valid && !req_retry_reg;

`ifdef DR_PF_DEDUP_EN
  logic [PF_DEPTH-1:0] pf_hit_vec;
  for (genvar gi = 0; gi < PF_DEPTH; gi++) begin : g_dedup
    logic [PA_W-1:0] slot_off;
    // Slot is live if it lies within count entries of the head
    assign slot_off       = PA_W'(gi) - pf_rd_ptr_reg;
    assign pf_hit_vec[gi] = ({1'b0, slot_off} < pf_count_reg) &&
                            (pf_mem[gi][PADDR_W-1:6] == l2todr_pfreq_paddr[PADDR_W-1:6]);
  end
  assign dedup_hit = l2todr_pfreq_valid &&
                     ((|pf_hit_vec) ||
                      (out_valid_reg && out_pf_reg &&
                       (out_paddr_reg[PADDR_W-1:6] == l2todr_pfreq_paddr[PADDR_W-1:6])));
`else
  assign dedup_hit = 1'b0;
`endif

  assign pf_push      = l2todr_pfreq_valid && !dedup_hit;
  assign pf_overwrite = pf_push && pf_full && !pf_pop;
  assign pf_drop_evt  = pf_overwrite || dedup_hit;

  always_comb begin
    req_count_next = req_count_reg;
    if (req_push && !req_pop)      req_count_next = req_count_reg + 1'b1;
    else if (!req_push && req_pop) req_count_next = req_count_reg - 1'b1;
  end

  // Queue storage writes
  always_ff @(posedge clk) begin
    if (req_push) req_mem[req_wr_ptr_reg] <= {l2todr_req_drid, l2todr_req_cmd, l2todr_req_paddr};
    if (pf_push)  pf_mem[pf_wr_ptr_reg]   <= {l2todr_pfreq_nid, l2todr_pfreq_paddr};
  end

  // Demand queue pointers, count and registered full-retry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_wr_ptr_reg <= '0;
      req_rd_ptr_reg <= '0;
      req_count_reg  <= '0;
      req_retry_reg  <= 1'b0;
    end else begin
      if (req_push) req_wr_ptr_reg <= req_wr_ptr_reg + 1'b1;
      if (req_pop)  req_rd_ptr_reg <= req_rd_ptr_reg + 1'b1;
      req_count_reg <= req_count_next;
      req_retry_reg <= (req_count_next == REQ_FULL);
    end
  end

  // Prefetch queue: overwrite-oldest when full, drop counter saturates
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pf_wr_ptr_reg   <= '0;
      pf_rd_ptr_reg   <= '0;
      pf_count_reg    <= '0;
      pf_drop_cnt_reg <= '0;
    end else begin
      if (pf_push) pf_wr_ptr_reg <= pf_wr_ptr_reg + 1'b1;
      if (pf_pop || pf_overwrite) pf_rd_ptr_reg <= pf_rd_ptr_reg + 1'b1;
      if (pf_push && !pf_pop && !pf_full) pf_count_reg <= pf_count_reg + 1'b1;
      else if (!pf_push && pf_pop)        pf_count_reg <= pf_count_reg - 1'b1;
      if (pf_drop_evt && (pf_drop_cnt_reg != 16'hFFFF))
        pf_drop_cnt_reg <= pf_drop_cnt_reg + 16'd1;
    end
  end

  // Starvation counter: counts demand grants made while a prefetch waits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_reg <= '0;
    end else if (pf_empty || pf_pop) begin
      starve_cnt_reg <= '0;
    end else if (req_pop) begin
      starve_cnt_reg <= starve_cnt_reg + 1'b1;
    end
  end

  // Output register: loads the arbitration winner from the queue head
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_reg <= 1'b0;
      out_drid_reg  <= '0;
      out_cmd_reg   <= '0;
      out_paddr_reg <= '0;
      out_nid_reg   <= '0;
      out_pf_reg    <= 1'b0;
    end else if (load_en) begin
      if (take_d) begin
        out_valid_reg <= 1'b1;
        {out_drid_reg, out_cmd_reg, out_paddr_reg} <= req_mem[req_rd_ptr_reg];
        out_nid_reg   <= '0;
        out_pf_reg    <= 1'b0;
      end else if (take_p) begin
        out_valid_reg <= 1'b1;
        out_drid_reg  <= '0;
        out_cmd_reg   <= PF_CMD;
        {out_nid_reg, out_paddr_reg} <= pf_mem[pf_rd_ptr_reg];
        out_pf_reg    <= 1'b1;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign l2todr_req_retry   = req_retry_reg;
  assign l2todr_pfreq_retry = 1'b0;
  assign drtomem_req_valid  = out_valid_reg;
  assign drtomem_req_drid   = out_drid_reg;
  assign drtomem_req_cmd    = out_cmd_reg;
  assign drtomem_req_paddr  = out_paddr_reg;
  assign drtomem_req_nid    = out_nid_reg;
  assign drtomem_req_pf     = out_pf_reg;
  assign pf_drop_cnt        = pf_drop_cnt_reg;

endmodule

// File: tb/tb_dr_memreq_sched.sv
// Directed testbench for dr_memreq_sched (small queues, PF_STARVE=2).
module tb_dr_memreq_sched;

  localparam int PADDR_W = 50;
  localparam int NID_W   = 5;
  localparam int DRID_W  = 6;
  localparam int CMD_W   = 3;
  localparam logic [CMD_W-1:0] PF_CMD = 3'd1;
`ifdef DR_PF_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               l2todr_req_valid = 1'b0;
  logic               l2todr_req_retry;
  logic [DRID_W-1:0]  l2todr_req_drid = '0;
  logic [CMD_W-1:0]   l2todr_req_cmd = '0;
  logic [PADDR_W-1:0] l2todr_req_paddr = '0;
  logic               l2todr_pfreq_valid = 1'b0;
  logic               l2todr_pfreq_retry;
  logic [NID_W-1:0]   l2todr_pfreq_nid = '0;
  logic [PADDR_W-1:0] l2todr_pfreq_paddr = '0;
  logic               drtomem_req_valid;
  logic               drtomem_req_retry = 1'b0;
  logic [DRID_W-1:0]  drtomem_req_drid;
  logic [CMD_W-1:0]   drtomem_req_cmd;
  logic [PADDR_W-1:0] drtomem_req_paddr;
  logic [NID_W-1:0]   drtomem_req_nid;
  logic               drtomem_req_pf;
  logic [15:0]        pf_drop_cnt;

  typedef struct packed {
    logic               pf;
    logic [DRID_W-1:0]  drid;
    logic [CMD_W-1:0]   cmd;
    logic [PADDR_W-1:0] paddr;
    logic [NID_W-1:0]   nid;
  } xfer_t;

  xfer_t got_q[$];
  int nvec = 0;
  int nerr = 0;
  int exp_drop = 0;

  dr_memreq_sched #(
    .REQ_DEPTH(4), .PF_DEPTH(4), .PADDR_W(PADDR_W), .NID_W(NID_W),
    .DRID_W(DRID_W), .CMD_W(CMD_W), .PF_STARVE(2), .PF_CMD(PF_CMD)
  ) dut (
    .clk(clk), .reset(reset),
    .l2todr_req_valid(l2todr_req_valid), .l2todr_req_retry(l2todr_req_retry),
    .l2todr_req_drid(l2todr_req_drid), .l2todr_req_cmd(l2todr_req_cmd),
    .l2todr_req_paddr(l2todr_req_paddr),
    .l2todr_pfreq_valid(l2todr_pfreq_valid), .l2todr_pfreq_retry(l2todr_pfreq_retry),
    .l2todr_pfreq_nid(l2todr_pfreq_nid), .l2todr_pfreq_paddr(l2todr_pfreq_paddr),
    .drtomem_req_valid(drtomem_req_valid), .drtomem_req_retry(drtomem_req_retry),
    .drtomem_req_drid(drtomem_req_drid), .drtomem_req_cmd(drtomem_req_cmd),
    .drtomem_req_paddr(drtomem_req_paddr), .drtomem_req_nid(drtomem_req_nid),
    .drtomem_req_pf(drtomem_req_pf), .pf_drop_cnt(pf_drop_cnt)
  );

  always #5 clk = ~clk;

  // Record every output transfer (valid && !retry seen before the edge)
  always @(negedge clk) begin
    if (reset && drtomem_req_valid && !drtomem_req_retry)
      got_q.push_back('{drtomem_req_pf, drtomem_req_drid, drtomem_req_cmd,
                        drtomem_req_paddr, drtomem_req_nid});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d required 0", 1);
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Present a demand request and hold it until accepted (bounded)
  task automatic push_req(input int id);
    logic r;
    int n;
    n = 0;
    l2todr_req_valid = 1'b1;
    l2todr_req_drid  = DRID_W'(id);
    l2todr_req_cmd   = 3'd2;
    l2todr_req_paddr = PADDR_W'(id * 64);
    do begin
      @(negedge clk);
      r = l2todr_req_retry;
      @(posedge clk);
      #1;
      n++;
    end while (r && n < 100);
    if (r) begin
      nvec++;
      nerr++;
      $display("FAIL push_req_timeout id=%0d: retry got 1 required 0", id);
    end
    l2todr_req_valid = 1'b0;
  endtask

  task automatic push_pf(input logic [PADDR_W-1:0] pa, input logic [NID_W-1:0] nid);
    l2todr_pfreq_valid = 1'b1;
    l2todr_pfreq_paddr = pa;
    l2todr_pfreq_nid   = nid;
    step;
    l2todr_pfreq_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) step;
    nvec++;
    if (drtomem_req_valid !== 1'b0) begin
      nerr++; $display("FAIL reset_valid: got %0b required 0", drtomem_req_valid);
    end
    nvec++;
    if ({drtomem_req_drid, drtomem_req_cmd, drtomem_req_paddr, drtomem_req_nid, drtomem_req_pf} !== '0) begin
      nerr++; $display("FAIL reset_payload: got %h required 0",
        {drtomem_req_drid, drtomem_req_cmd, drtomem_req_paddr, drtomem_req_nid, drtomem_req_pf});
    end
    nvec++;
    if (l2todr_req_retry !== 1'b0 || l2todr_pfreq_retry !== 1'b0) begin
      nerr++; $display("FAIL reset_retry: got %0b%0b required 00", l2todr_req_retry, l2todr_pfreq_retry);
    end
    nvec++;
    if (pf_drop_cnt !== 16'd0) begin
      nerr++; $display("FAIL reset_dropcnt: got %0d required 0", pf_drop_cnt);
    end
    reset = 1'b1;
    step;
  endtask

  task automatic test_demand_order;
    got_q.delete();
    drtomem_req_retry = 1'b0;
    l2todr_req_valid = 1'b1; l2todr_req_cmd = 3'd2;
    for (int i = 1; i <= 4; i++) begin
      if (i <= 3) begin
        l2todr_req_drid  = DRID_W'(i);
        l2todr_req_paddr = PADDR_W'(i * 64);
      end else begin
        l2todr_req_valid = 1'b0;
      end
      step;
      nvec++;
      if (i == 1) begin
        if (drtomem_req_valid !== 1'b0) begin
          nerr++; $display("FAIL order_latency: valid got %0b required 0 after push edge", drtomem_req_valid);
        end
      end else if (drtomem_req_valid !== 1'b1 || drtomem_req_drid !== DRID_W'(i - 1) ||
                   drtomem_req_pf !== 1'b0 || drtomem_req_nid !== '0) begin
        nerr++; $display("FAIL order_out%0d: got v=%0b drid=%0d pf=%0b nid=%0d required v=1 drid=%0d pf=0 nid=0",
          i - 1, drtomem_req_valid, drtomem_req_drid, drtomem_req_pf, drtomem_req_nid, i - 1);
      end
    end
    step;
    nvec++;
    if (got_q.size() != 3 || got_q[0].drid !== 6'd1 || got_q[1].drid !== 6'd2 || got_q[2].drid !== 6'd3) begin
      nerr++; $display("FAIL order_stream: got %0d transfers required 3 with drid 1,2,3", got_q.size());
    end
  endtask

  task automatic test_req_backpressure;
    got_q.delete();
    drtomem_req_retry = 1'b1;
    for (int id = 11; id <= 14; id++) push_req(id);
    nvec++;
    if (l2todr_req_retry !== 1'b0) begin
      nerr++; $display("FAIL bp_not_full: retry got %0b required 0 with 3 queued", l2todr_req_retry);
    end
    push_req(15);
    nvec++;
    if (l2todr_req_retry !== 1'b1) begin
      nerr++; $display("FAIL bp_full: retry got %0b required 1 with 4 queued", l2todr_req_retry);
    end
    fork
      push_req(16);
      begin
        step; step;
        drtomem_req_retry = 1'b0;
      end
    join
    for (int c = 0; c < 40 && got_q.size() < 6; c++) step;
    nvec++;
    if (got_q.size() != 6) begin
      nerr++; $display("FAIL bp_count: got %0d transfers required 6", got_q.size());
    end
    for (int k = 0; k < 6 && k < got_q.size(); k++) begin
      nvec++;
      if (got_q[k].drid !== DRID_W'(11 + k) || got_q[k].pf !== 1'b0) begin
        nerr++; $display("FAIL bp_order%0d: got drid=%0d pf=%0b required drid=%0d pf=0",
          k, got_q[k].drid, got_q[k].pf, 11 + k);
      end
    end
  endtask

  task automatic test_pf_drop;
    int exp_k[5];
    exp_k = '{0, 3, 4, 5, 6};
    got_q.delete();
    drtomem_req_retry = 1'b1;
    for (int k = 0; k <= 6; k++) push_pf(PADDR_W'(64 * k), NID_W'(k + 1));
    step;
    exp_drop += 2;
    nvec++;
    if (pf_drop_cnt !== 16'(exp_drop)) begin
      nerr++; $display("FAIL pf_dropcnt: got %0d required %0d", pf_drop_cnt, exp_drop);
    end
    nvec++;
    if (drtomem_req_valid !== 1'b1 || drtomem_req_pf !== 1'b1 || drtomem_req_paddr !== '0) begin
      nerr++; $display("FAIL pf_hold: got v=%0b pf=%0b paddr=%h required v=1 pf=1 paddr=0",
        drtomem_req_valid, drtomem_req_pf, drtomem_req_paddr);
    end
    drtomem_req_retry = 1'b0;
    for (int c = 0; c < 20; c++) step;
    nvec++;
    if (got_q.size() != 5) begin
      nerr++; $display("FAIL pf_drain_count: got %0d required 5", got_q.size());
    end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      nvec++;
      if (got_q[i].paddr !== PADDR_W'(64 * exp_k[i]) || got_q[i].nid !== NID_W'(exp_k[i] + 1) ||
          got_q[i].pf !== 1'b1 || got_q[i].drid !== '0 || got_q[i].cmd !== PF_CMD) begin
        nerr++; $display("FAIL pf_drain%0d: got paddr=%h nid=%0d pf=%0b drid=%0d cmd=%0d required paddr=%h nid=%0d pf=1 drid=0 cmd=%0d",
          i, got_q[i].paddr, got_q[i].nid, got_q[i].pf, got_q[i].drid, got_q[i].cmd,
          64 * exp_k[i], exp_k[i] + 1, PF_CMD);
      end
    end
  endtask

  task automatic test_pf_push_pop;
    got_q.delete();
    drtomem_req_retry = 1'b1;
    for (int k = 0; k <= 4; k++) push_pf(PADDR_W'(32'h2000 + 64 * k), NID_W'(k));
    // Queue now full; one cycle of simultaneous pop and push
    drtomem_req_retry  = 1'b0;
    push_pf(PADDR_W'(32'h2000 + 64 * 5), NID_W'(5));
    drtomem_req_retry  = 1'b1;
    nvec++;
    if (pf_drop_cnt !== 16'(exp_drop)) begin
      nerr++; $display("FAIL pushpop_dropcnt: got %0d required %0d", pf_drop_cnt, exp_drop);
    end
    step;
    drtomem_req_retry = 1'b0;
    for (int c = 0; c < 20; c++) step;
    nvec++;
    if (got_q.size() != 6) begin
      nerr++; $display("FAIL pushpop_count: got %0d required 6", got_q.size());
    end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      nvec++;
      if (got_q[i].paddr !== PADDR_W'(32'h2000 + 64 * i) || got_q[i].nid !== NID_W'(i)) begin
        nerr++; $display("FAIL pushpop_order%0d: got paddr=%h nid=%0d required paddr=%h nid=%0d",
          i, got_q[i].paddr, got_q[i].nid, 32'h2000 + 64 * i, i);
      end
    end
  endtask

  task automatic test_starve;
    bit exp_pf[6];
    int exp_id[6];
    exp_pf = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_id = '{21, 22, 0, 23, 24, 25};
    got_q.delete();
    drtomem_req_retry = 1'b0;
    l2todr_pfreq_valid = 1'b1;
    l2todr_pfreq_paddr = PADDR_W'(32'h3000);
    l2todr_pfreq_nid   = 5'd7;
    fork
      push_req(21);
      begin step; l2todr_pfreq_valid = 1'b0; end
    join
    for (int id = 22; id <= 25; id++) push_req(id);
    for (int c = 0; c < 20 && got_q.size() < 6; c++) step;
    step;
    nvec++;
    if (got_q.size() != 6) begin
      nerr++; $display("FAIL starve_count: got %0d required 6", got_q.size());
    end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      nvec++;
      if (got_q[i].pf !== exp_pf[i] || got_q[i].drid !== DRID_W'(exp_id[i])) begin
        nerr++; $display("FAIL starve_grant%0d: got pf=%0b drid=%0d required pf=%0b drid=%0d",
          i, got_q[i].pf, got_q[i].drid, exp_pf[i], exp_id[i]);
      end
    end
  endtask

  task automatic test_dedup;
    int exp_n;
    exp_n = DEDUP ? 2 : 3;
    got_q.delete();
    drtomem_req_retry = 1'b1;
    push_req(31);
    push_pf(PADDR_W'(32'h1000), 5'd1);
    push_pf(PADDR_W'(32'h1020), 5'd2);
    step;
    exp_drop += DEDUP ? 1 : 0;
    nvec++;
    if (pf_drop_cnt !== 16'(exp_drop)) begin
      nerr++; $display("FAIL dedup_dropcnt: got %0d required %0d", pf_drop_cnt, exp_drop);
    end
    drtomem_req_retry = 1'b0;
    for (int c = 0; c < 10; c++) step;
    nvec++;
    if (got_q.size() != exp_n) begin
      nerr++; $display("FAIL dedup_count: got %0d transfers required %0d", got_q.size(), exp_n);
    end
    nvec++;
    if (got_q.size() >= 2 && (got_q[0].drid !== 6'd31 || got_q[1].paddr !== PADDR_W'(32'h1000))) begin
      nerr++; $display("FAIL dedup_order: got drid=%0d paddr=%h required drid=31 paddr=1000",
        got_q[0].drid, got_q[1].paddr);
    end
  endtask

  task automatic test_reset_midop;
    got_q.delete();
    drtomem_req_retry = 1'b1;
    for (int id = 41; id <= 43; id++) push_req(id);
    for (int k = 0; k <= 5; k++) push_pf(PADDR_W'(32'h5000 + 64 * k), 5'd3);
    #3;
    reset = 1'b0;
    #1;
    nvec++;
    if (drtomem_req_valid !== 1'b0 || drtomem_req_drid !== '0 || drtomem_req_paddr !== '0) begin
      nerr++; $display("FAIL midreset_out: got v=%0b drid=%0d paddr=%h required 0",
        drtomem_req_valid, drtomem_req_drid, drtomem_req_paddr);
    end
    nvec++;
    if (pf_drop_cnt !== 16'd0) begin
      nerr++; $display("FAIL midreset_dropcnt: got %0d required 0", pf_drop_cnt);
    end
    exp_drop = 0;
    step; step;
    reset = 1'b1;
    drtomem_req_retry = 1'b0;
    for (int c = 0; c < 6; c++) step;
    nvec++;
    if (got_q.size() != 0 || drtomem_req_valid !== 1'b0) begin
      nerr++; $display("FAIL midreset_flush: got %0d transfers valid=%0b required 0 transfers valid=0",
        got_q.size(), drtomem_req_valid);
    end
  endtask

  initial begin
    test_reset;
    test_demand_order;
    test_req_backpressure;
    test_pf_drop;
    test_pf_push_pop;
    test_starve;
    test_dedup;
    test_reset_midop;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dr_memreq_sched.md
# dr_memreq_sched

Parametrised memory-side request scheduler for the directory bank. It holds demand misses and L2 prefetch requests in two separate queues and merges them onto one request channel toward memory. Demand traffic has priority, and a starvation counter guarantees that prefetches still make progress. When the prefetch queue is full it drops its oldest entry instead of back-pressuring the L2s.

## Interface
Parameters:
- REQ_DEPTH, 8, demand queue entries; must be a power of two, 4–16.
- PF_DEPTH, 8, prefetch queue entries; must be a power of two, 4–16.
- PADDR_W, 50, physical address width.
- NID_W, 5, node id width.
- DRID_W, 6, directory request id width.
- CMD_W, 3, command width.
- PF_STARVE, 15, maximum consecutive demand grants while a prefetch waits; must be ≥1.
- PF_CMD, 3'd1, value driven on the cmd field for prefetch grants.

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous, active-low reset.
- l2todr_req_valid / l2todr_req_retry, in/out, 1/1, demand input handshake.
- l2todr_req_drid / l2todr_req_cmd / l2todr_req_paddr, in, DRID_W/CMD_W/PADDR_W, demand payload.
- l2todr_pfreq_valid / l2todr_pfreq_retry, in/out, 1/1, prefetch input handshake; retry is tied to 0.
- l2todr_pfreq_nid / l2todr_pfreq_paddr, in, NID_W/PADDR_W, prefetch payload.
- drtomem_req_valid / drtomem_req_retry, out/in, 1/1, merged output handshake.
- drtomem_req_drid / drtomem_req_cmd / drtomem_req_paddr / drtomem_req_nid, out, DRID_W/CMD_W/PADDR_W/NID_W, merged payload.
- drtomem_req_pf, out, 1, 1 = entry came from the prefetch queue.
- pf_drop_cnt, out, 16, saturating count of dropped prefetches.

## Operation
- Handshake: a transfer occurs in a cycle where valid=1 and retry=0. A sender must hold valid and payload stable while retry=1.
- Demand queue: FIFO.
  - l2todr_req_retry = (req_count == REQ_DEPTH), registered.
  - Retry stays asserted when full, even if a pop happens in the same cycle.
- Prefetch queue: FIFO, never retried.
  - A push when full and not popped in the same cycle overwrites the oldest entry: the head advances with the tail, count is unchanged, and pf_drop_cnt increments.
  - A push when full with a pop in the same cycle is not a drop.
- Output register: a single stage. It loads when empty, or when its contents transfer in the same cycle.
- Arbitration at load time:
  - Only one queue non-empty: take from that queue.
  - Both non-empty: take demand, unless starve_cnt == PF_STARVE, in which case take prefetch.
- starve_cnt:
  - Increments on each demand grant while the prefetch queue is non-empty.
  - Clears on a prefetch grant, or whenever the prefetch queue is empty.
- Prefetch grant field values: drid = 0, cmd = PF_CMD, nid = the queued nid, pf = 1.
- Demand grant field values: nid = 0, pf = 0.
- pf_drop_cnt saturates at 16'hFFFF.

## Timing
- Reset values (asynchronous, reset low):
  - All queues empty, output register invalid, starve_cnt = 0, pf_drop_cnt = 0.
  - drtomem_req_valid = 0 and all payload outputs = 0.
  - l2todr_req_retry = 0, l2todr_pfreq_retry = 0.
- Reset may assert mid-operation. Queued entries are discarded without being emitted, and outputs return to their reset values in that same cycle.
- Latency: an entry accepted at edge N is visible on drtomem_req at N+1 (earliest).
- Throughput: one transfer per cycle while drtomem_req_retry = 0.
- Hold: while drtomem_req_retry = 1, the output register holds its value; queues keep accepting input and the prefetch queue keeps dropping.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH; count is log2(DEPTH)+1 bits.

## Configuration
DR_PF_DEDUP_EN.
- Defined: an incoming prefetch whose line address (paddr[PADDR_W-1:6]) equals the line address of any valid prefetch-queue entry, or of an output-register entry with pf=1, is discarded. The queue is unchanged and pf_drop_cnt increments.
- Not defined: no compare logic; every prefetch is enqueued.

## Test plan
- Reset release, 3 demand pushes (drid 1, 2, 3), retry=0: outputs appear in order 1, 2, 3 on consecutive cycles, pf=0, first output one cycle after the first push.
- REQ_DEPTH=4, output retry held at 1, 6 demand pushes: l2todr_req_retry=1 after the 4th queue entry is accepted; release retry → all accepted ids emerge in order, none lost.
- PF_DEPTH=4, output retry held at 1, 7 prefetches with paddr 0x40·k (k=0..6): pf_drop_cnt = 2 (one entry sits in the output register); release retry → the output-register entry comes out first, then k = 3, 4, 5, 6.
- PF_STARVE=2, queue of 5 demands and 1 prefetch, retry=0: grant order D, D, P, D, D, D.
- Simultaneous full-queue prefetch push and pop: pf_drop_cnt unchanged, count unchanged.
- With DR_PF_DEDUP_EN defined: prefetch 0x1000 followed by 0x1020 (same line) with output retry held at 1: queue holds one entry, pf_drop_cnt = 1. Without the macro: the second prefetch is queued as its own entry and the count is unchanged.
